// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM encoding,
// word geometry and checksum helper.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_HI,
      LEN_LO,
      DATA,
      CSUM,
      DONE,
      ERROR
   } state_t;

   localparam int         WORD_BYTES = 4;
   localparam logic [7:0] CSUM_INIT  = 8'h00;

   function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
interface imem_loader_if #(
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  im_we;
   logic [ADDR_WIDTH-1:0] im_addr;
   logic [31:0]           im_wdata;

   modport master (
      input  in_data, in_valid,
      output in_ready, im_we, im_addr, im_wdata
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, im_we, im_addr, im_wdata
   );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs bytes MSB-first into 32-bit words; pulses word_valid for one cycle
// after the last byte of each word has been accepted.
module imem_word_assembler
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        byte_last,
   output logic        word_valid,
   output logic [31:0] word
);

   localparam int CNT_W = $clog2(WORD_BYTES);
   localparam int SH_W  = 8 * (WORD_BYTES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [SH_W-1:0]  shift_q, shift_d;
   logic             word_valid_q, word_valid_d;
   logic [31:0]      word_q, word_d;

   assign byte_last  = (cnt_q == CNT_W'(WORD_BYTES - 1));
   assign word_valid = word_valid_q;
   assign word       = word_q;

   always_comb begin
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      word_valid_d = 1'b0;
      word_d       = word_q;
      if (clr) begin
         cnt_d   = '0;
         shift_d = '0;
      end else if (byte_en) begin
         // Counter wraps naturally after the last byte of a word.
         cnt_d   = cnt_q + 1'b1;
         shift_d = {shift_q[SH_W-9:0], byte_in};
         if (byte_last) begin
            word_valid_d = 1'b1;
            word_d       = {shift_q, byte_in};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q        <= '0;
         shift_q      <= '0;
         word_valid_q <= 1'b0;
         word_q       <= '0;
      end else begin
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         word_valid_q <= word_valid_d;
         word_q       <= word_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: length-prefixed, XOR-checksummed byte
// stream in, sequential word writes out; holds the CPU in reset until verified.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   imem_loader_if.master bus,
   output logic          cpu_reset,
   output logic          done,
   output logic          error,
   output logic [15:0]   words_loaded
);

   localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;

   state_t                state_q, state_d;
   logic [15:0]           len_q, len_d;
   logic [7:0]            csum_q, csum_d;
   logic [15:0]           wcnt_q, wcnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           words_q, words_d;

   logic        xfer;
   logic        clr;
   logic        byte_last;
   logic        word_valid;
   logic [31:0] word;
   logic [15:0] len_new;
   logic [15:0] len_m1;

   assign bus.in_ready = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                         (state_q == DATA)   || (state_q == CSUM);
   assign xfer         = bus.in_valid && bus.in_ready;
   assign len_new      = {len_q[15:8], bus.in_data};
   assign len_m1       = len_q - 16'd1;

   imem_word_assembler u_asm (
      .clk        (clk),
      .reset      (reset),
      .clr        (clr),
      .byte_en    (xfer && (state_q == DATA)),
      .byte_in    (bus.in_data),
      .byte_last  (byte_last),
      .word_valid (word_valid),
      .word       (word)
   );

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      csum_d  = csum_q;
      wcnt_d  = wcnt_q;
      addr_d  = addr_q;
      words_d = words_q;
      clr     = 1'b0;

      // The write pulse lags its last byte by a cycle, so it may land in CSUM.
      if (word_valid) begin
         addr_d  = addr_q + 1'b1;
         words_d = words_q + 16'd1;
      end

      case (state_q)
         IDLE, DONE, ERROR: begin
            if (start) begin
               state_d = LEN_HI;
               csum_d  = CSUM_INIT;
               wcnt_d  = '0;
               addr_d  = '0;
               words_d = '0;
               clr     = 1'b1;
            end
         end
         LEN_HI: begin
            if (xfer) begin
               len_d[15:8] = bus.in_data;
               csum_d      = csum_next(csum_q, bus.in_data);
               state_d     = LEN_LO;
            end
         end
         LEN_LO: begin
            if (xfer) begin
               len_d  = len_new;
               csum_d = csum_next(csum_q, bus.in_data);
               if ({1'b0, len_new} > DEPTH) state_d = ERROR;
               else if (len_new == 16'd0)   state_d = CSUM;
               else                         state_d = DATA;
            end
         end
         DATA: begin
            if (xfer) begin
               csum_d = csum_next(csum_q, bus.in_data);
               if (byte_last) begin
                  wcnt_d = wcnt_q + 16'd1;
                  if (wcnt_q == len_m1) state_d = CSUM;
               end
            end
         end
         CSUM: begin
            if (xfer) state_d = (bus.in_data == csum_q) ? DONE : ERROR;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         len_q   <= '0;
         csum_q  <= CSUM_INIT;
         wcnt_q  <= '0;
         addr_q  <= '0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         csum_q  <= csum_d;
         wcnt_q  <= wcnt_d;
         addr_q  <= addr_d;
         words_q <= words_d;
      end
   end

   assign bus.im_we    = word_valid;
   assign bus.im_addr  = addr_q;
   assign bus.im_wdata = word;
   assign cpu_reset    = (state_q != DONE);
   assign done         = (state_q == DONE);
   assign error        = (state_q == ERROR);
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: load, checksum/length errors, zero length,
// stalls, mid-load reset, reload and a full-depth image.
module tb_imem_loader;

   localparam int AW = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        cpu_reset;
   logic        done;
   logic        error;
   logic [15:0] words_loaded;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .bus          (bus),
      .cpu_reset    (cpu_reset),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   logic [31:0]   wlist[$];
   logic [7:0]    stream[$];

   always @(negedge clk) begin
      if (bus.im_we === 1'b1) begin
         wr_addr.push_back(bus.im_addr);
         wr_data.push_back(bus.im_wdata);
      end
   end

   task automatic build(input logic [15:0] n, input logic [7:0] flip);
      logic [7:0]  c;
      logic [31:0] w;
      stream.delete();
      c = n[15:8] ^ n[7:0];
      stream.push_back(n[15:8]);
      stream.push_back(n[7:0]);
      foreach (wlist[i]) begin
         w = wlist[i];
         for (int k = 3; k >= 0; k--) begin
            stream.push_back(w[8*k +: 8]);
            c = c ^ w[8*k +: 8];
         end
      end
      stream.push_back(c ^ flip);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      repeat (gap) begin
         bus.in_valid = 1'b0;
         @(negedge clk);
      end
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("ready_timeout", 32'(bus.in_ready), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_stream(input bit gaps);
      foreach (stream[i]) send_byte(stream[i], gaps ? int'($urandom_range(0, 3)) : 0);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
   endtask

   task automatic check_writes(input string tag);
      chk({tag, "_nwr"}, 32'(wr_data.size()), 32'(wlist.size()));
      for (int i = 0; i < wlist.size() && i < wr_data.size(); i++) begin
         chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(i % (1 << AW)));
         chk($sformatf("%s_data%0d", tag, i), wr_data[i], wlist[i]);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      repeat (3) @(negedge clk);

      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_im_we", 32'(bus.im_we), 0);
      chk("rst_im_addr", 32'(bus.im_addr), 0);
      chk("rst_im_wdata", bus.im_wdata, 0);
      chk("rst_cpu_reset", 32'(cpu_reset), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_words", 32'(words_loaded), 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_in_ready", 32'(bus.in_ready), 0);

      // Bubble-sort prologue, 3 words at full rate
      wlist = '{32'h20100200, 32'h2011000B, 32'h00009020};
      build(16'd3, 8'h00);
      chk("bs_csum", 32'(stream[stream.size()-1]), 32'h000000BB);
      clear_log();
      pulse_start();
      chk("bs_cpurst_load", 32'(cpu_reset), 1);
      chk("bs_in_ready", 32'(bus.in_ready), 1);
      send_stream(1'b0);
      chk("bs_done", 32'(done), 1);
      chk("bs_cpurst", 32'(cpu_reset), 0);
      chk("bs_error", 32'(error), 0);
      repeat (2) @(negedge clk);
      check_writes("bs");
      chk("bs_words", 32'(words_loaded), 3);

      // Checksum error (start issued from DONE)
      build(16'd3, 8'h01);
      clear_log();
      pulse_start();
      chk("ce_done_clr", 32'(done), 0);
      chk("ce_words_clr", 32'(words_loaded), 0);
      send_stream(1'b0);
      chk("ce_error", 32'(error), 1);
      chk("ce_done", 32'(done), 0);
      chk("ce_cpurst", 32'(cpu_reset), 1);
      repeat (2) @(negedge clk);
      check_writes("ce");
      chk("ce_words", 32'(words_loaded), 3);

      // Length 257 exceeds DEPTH=256
      wlist.delete();
      clear_log();
      pulse_start();
      chk("le_err_clr", 32'(error), 0);
      send_byte(8'h01, 0);
      send_byte(8'h01, 0);
      chk("le_error", 32'(error), 1);
      chk("le_in_ready", 32'(bus.in_ready), 0);
      bus.in_data  = 8'h55;
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("le_in_ready2", 32'(bus.in_ready), 0);
      chk("le_nwr", 32'(wr_data.size()), 0);
      chk("le_cpurst", 32'(cpu_reset), 1);

      // Zero length, good then bad checksum
      build(16'd0, 8'h00);
      pulse_start();
      send_stream(1'b0);
      chk("z_done", 32'(done), 1);
      chk("z_error", 32'(error), 0);
      chk("z_cpurst", 32'(cpu_reset), 0);
      build(16'd0, 8'h01);
      pulse_start();
      send_stream(1'b0);
      chk("z1_error", 32'(error), 1);
      chk("z1_done", 32'(done), 0);
      chk("z_nwr", 32'(wr_data.size()), 0);

      // 23 words, gap-free then with random stalls
      wlist.delete();
      for (int i = 0; i < 23; i++)
         wlist.push_back({8'(i), 8'(i) ^ 8'h5A, 8'hC3, 8'(i * 7)});
      build(16'd23, 8'h00);
      clear_log();
      pulse_start();
      send_stream(1'b0);
      chk("s0_done", 32'(done), 1);
      repeat (2) @(negedge clk);
      check_writes("s0");
      clear_log();
      pulse_start();
      send_stream(1'b1);
      chk("s1_done", 32'(done), 1);
      repeat (2) @(negedge clk);
      check_writes("s1");
      chk("s1_words", 32'(words_loaded), 23);

      // Reset after two data bytes, then a clean 1-word load
      pulse_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("mr_in_ready", 32'(bus.in_ready), 0);
      chk("mr_cpurst", 32'(cpu_reset), 1);
      chk("mr_words", 32'(words_loaded), 0);
      chk("mr_im_addr", 32'(bus.im_addr), 0);
      chk("mr_done", 32'(done), 0);
      wlist = '{32'h12345678};
      build(16'd1, 8'h00);
      clear_log();
      pulse_start();
      send_stream(1'b0);
      chk("mr_done2", 32'(done), 1);
      repeat (2) @(negedge clk);
      check_writes("mr");

      // Reload from DONE
      wlist = '{32'h08000007};
      build(16'd1, 8'h00);
      clear_log();
      pulse_start();
      chk("rl_cpurst", 32'(cpu_reset), 1);
      chk("rl_done_clr", 32'(done), 0);
      chk("rl_words_clr", 32'(words_loaded), 0);
      send_stream(1'b0);
      chk("rl_done", 32'(done), 1);
      repeat (2) @(negedge clk);
      check_writes("rl");
      chk("rl_words", 32'(words_loaded), 1);

      // Full-depth image: N = DEPTH is legal, last index DEPTH-1
      wlist.delete();
      for (int i = 0; i < 256; i++)
         wlist.push_back({8'(i), ~8'(i), 8'(i) ^ 8'h55, 8'h3C});
      build(16'd256, 8'h00);
      clear_log();
      pulse_start();
      send_stream(1'b0);
      chk("fd_done", 32'(done), 1);
      repeat (2) @(negedge clk);
      check_writes("fd");
      chk("fd_words", 32'(words_loaded), 256);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
